// File: rtl/fpu_issue_ctrl.sv
// Issue/completion controller for the multi-cycle FPU. It times the op latency, keeps a
// one-entry scoreboard on the destination register, and arbitrates the FP write port.
module fpu_issue_ctrl #(
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 16,
    parameter int LAT_SQRT = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       o_p_waitrequest,
    input  logic       issue_valid_i,
    input  logic       op_add_i,
    input  logic       op_sub_i,
    input  logic       op_mul_i,
    input  logic       op_div_i,
    input  logic       op_sqrt_i,
    input  logic [4:0] rd_i,
    input  logic       dec_fp_arith_i,
    input  logic       dec_fp_use_i,
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic       int_wb_req_i,
    output logic       fpu_start_o,
    output logic [2:0] fpu_op_o,
    output logic       fwb_en_o,
    output logic [4:0] fwb_rd_o,
    output logic       stall_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    pend_rd;
    logic [4:0]    op_vec;
    logic          op_one_hot;
    logic [2:0]    op_code;
    logic [CW-1:0] lat_m1;
    logic          raw_hit;

    assign op_vec     = {op_sqrt_i, op_div_i, op_mul_i, op_sub_i, op_add_i};
    assign op_one_hot = $onehot(op_vec);

    // Encoding and latency lookup only matter when the select is one-hot.
    always_comb begin
        op_code = 3'd0;
        lat_m1  = CW'(LAT_ADD - 1);
        if (op_sub_i) begin
            op_code = 3'd1;
            lat_m1  = CW'(LAT_ADD - 1);
        end else if (op_mul_i) begin
            op_code = 3'd2;
            lat_m1  = CW'(LAT_MUL - 1);
        end else if (op_div_i) begin
            op_code = 3'd3;
            lat_m1  = CW'(LAT_DIV - 1);
        end else if (op_sqrt_i) begin
            op_code = 3'd4;
            lat_m1  = CW'(LAT_SQRT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_rd     <= '0;
            fpu_op_o    <= '0;
            fpu_start_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle; non-blocking keeps every read on the old state.
            fpu_start_o <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_valid_i && !o_p_waitrequest) begin
                        if (op_one_hot) begin
                            pend_rd     <= rd_i;
                            fpu_op_o    <= op_code;
                            cnt         <= lat_m1;
                            fpu_start_o <= 1'b1;
                            state       <= EXEC;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                // The FPU datapath is not frozen by memory stalls, so neither is the count.
                EXEC: begin
                    if (cnt == '0) state <= WB;
                    else           cnt   <= cnt - 1'b1;
                end
                WB: begin
                    if (!int_wb_req_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state != IDLE);
    assign fwb_en_o = (state == WB) && !int_wb_req_i;
    assign fwb_rd_o = (state == WB) ? pend_rd : 5'd0;

    // Stall holds through the write cycle; the register file has no write-through path.
    assign raw_hit = dec_fp_use_i && ((dec_rs1_i == pend_rd) || (dec_rs2_i == pend_rd));
    assign stall_o = busy_o && (dec_fp_arith_i || raw_hit);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a cycle-arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed latencies and counts.
module tb_fpu_issue_ctrl;

    localparam int LA = 3, LM = 4, LD = 16, LS = 16;
    localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00100,
                           DIV = 5'b01000, SQRT = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       o_p_waitrequest = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic [4:0] ops = 5'd0;
    logic [4:0] rd_i = 5'd0;
    logic       dec_fp_arith_i = 1'b0, dec_fp_use_i = 1'b0;
    logic [4:0] dec_rs1_i = 5'd0, dec_rs2_i = 5'd0;
    logic       int_wb_req_i = 1'b0;
    logic       fpu_start_o, fwb_en_o, stall_o, busy_o, err_o;
    logic [2:0] fpu_op_o;
    logic [4:0] fwb_rd_o;

    fpu_issue_ctrl #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_SQRT(LS), .CW(5)) dut (
        .clk(clk), .rst(rst), .o_p_waitrequest(o_p_waitrequest),
        .issue_valid_i(issue_valid_i),
        .op_add_i(ops[0]), .op_sub_i(ops[1]), .op_mul_i(ops[2]), .op_div_i(ops[3]), .op_sqrt_i(ops[4]),
        .rd_i(rd_i), .dec_fp_arith_i(dec_fp_arith_i), .dec_fp_use_i(dec_fp_use_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .int_wb_req_i(int_wb_req_i),
        .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o), .fwb_en_o(fwb_en_o), .fwb_rd_o(fwb_rd_o),
        .stall_o(stall_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an op in flight is described by its start cycle and latency only.
    int         cyc = 0;
    logic       m_active = 1'b0;
    int         m_start = 0, m_lat = 0, m_err_cyc = -1;
    logic [2:0] m_op = 3'd0;
    logic [4:0] m_rd = 5'd0;

    function automatic int ones(input logic [4:0] v);
        int s = 0;
        for (int i = 0; i < 5; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic int lat_of(input logic [4:0] v);
        if (v == ADD || v == SUB) return LA;
        if (v == MUL) return LM;
        if (v == DIV) return LD;
        return LS;
    endfunction

    function automatic logic [2:0] code_of(input logic [4:0] v);
        case (v)
            ADD: return 3'd0;
            SUB: return 3'd1;
            MUL: return 3'd2;
            DIV: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 0; m_active <= 1'b0; m_start <= 0; m_lat <= 0;
            m_err_cyc <= -1; m_op <= 3'd0; m_rd <= 5'd0;
        end else begin
            cyc <= cyc + 1;
            if (m_active) begin
                if (cyc >= m_start + m_lat && !int_wb_req_i) m_active <= 1'b0;
            end else if (issue_valid_i && !o_p_waitrequest) begin
                if (ones(ops) == 1) begin
                    m_active <= 1'b1;
                    m_start  <= cyc + 1;
                    m_lat    <= lat_of(ops);
                    m_op     <= code_of(ops);
                    m_rd     <= rd_i;
                end else begin
                    m_err_cyc <= cyc + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic wb_phase;
        logic raw;
        wb_phase = m_active && (cyc >= m_start + m_lat);
        raw      = dec_fp_use_i && (dec_rs1_i == m_rd || dec_rs2_i == m_rd);
        check("busy",  32'(busy_o),      32'(m_active));
        check("start", 32'(fpu_start_o), 32'(m_active && cyc == m_start));
        check("fwb_en", 32'(fwb_en_o),   32'(wb_phase && !int_wb_req_i));
        check("fwb_rd", 32'(fwb_rd_o),   wb_phase ? 32'(m_rd) : 32'd0);
        check("fpu_op", 32'(fpu_op_o),   32'(m_op));
        check("err",   32'(err_o),       32'(cyc == m_err_cyc));
        check("stall", 32'(stall_o),     32'(m_active && (dec_fp_arith_i || raw)));
    end

    // Event statistics for the directed literal expectations.
    int   n_start, n_wb, n_stall, n_err, n_rdnz, t_start, t_wb, t_idle, t_err;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (fpu_start_o) begin n_start++; t_start = cyc; end
        if (fwb_en_o)    begin n_wb++;    t_wb    = cyc; end
        if (stall_o)     n_stall++;
        if (err_o)       begin n_err++;   t_err   = cyc; end
        if (fwb_rd_o != 5'd0) n_rdnz++;
        if (prev_busy && !busy_o) t_idle = cyc;
        prev_busy = busy_o;
    end

    task automatic clear_stats();
        n_start = 0; n_wb = 0; n_stall = 0; n_err = 0; n_rdnz = 0;
        t_start = -1; t_wb = -1; t_idle = -1; t_err = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [4:0] v, input logic [4:0] rd);
        issue_valid_i = 1'b1; ops = v; rd_i = rd;
        step(1);
        issue_valid_i = 1'b0; ops = 5'd0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy_o && k < 60) begin
            step(1);
            k++;
        end
        if (k >= 60) begin
            n_checks++; n_errors++;
            $display("FAIL %s: busy did not fall within 60 cycles", name);
        end
        step(2);
    endtask

    initial begin
        int c0;
        clear_stats();
        step(2);
        check("reset_busy",  32'(busy_o), 0);
        check("reset_fwb",   32'(fwb_en_o), 0);
        check("reset_op",    32'(fpu_op_o), 0);
        rst = 1'b1;
        step(2);

        // fadd rd=5, uncontended
        clear_stats();
        issue(ADD, 5'd5);
        wait_idle("fadd");
        check("fadd_lat",     32'(t_wb - t_start), 3);
        check("fadd_idle",    32'(t_idle - t_start), 4);
        check("fadd_wb_once", 32'(n_wb), 1);

        // fdiv rd=7 with decode reading f7
        clear_stats();
        dec_fp_use_i = 1'b1; dec_rs1_i = 5'd7; dec_rs2_i = 5'd1;
        issue(DIV, 5'd7);
        wait_idle("fdiv_raw");
        check("fdiv_raw_stall", 32'(n_stall), 17);
        check("fdiv_op", 32'(fpu_op_o), 3);

        // fdiv rd=7 with decode reading f8, not arithmetic
        clear_stats();
        dec_rs1_i = 5'd8; dec_rs2_i = 5'd8;
        issue(DIV, 5'd7);
        wait_idle("fdiv_noraw");
        check("fdiv_noraw_stall", 32'(n_stall), 0);
        dec_fp_use_i = 1'b0;

        // fmul in flight, fsub waiting in decode
        clear_stats();
        dec_fp_arith_i = 1'b1;
        issue(MUL, 5'd3);
        wait_idle("fmul_struct");
        check("fmul_struct_stall", 32'(n_stall), 5);
        dec_fp_arith_i = 1'b0;
        issue(SUB, 5'd4);
        wait_idle("fsub_after");
        check("fsub_starts", 32'(n_start), 2);
        check("fsub_op", 32'(fpu_op_o), 1);

        // Writeback contention for the first two WB cycles
        clear_stats();
        issue(ADD, 5'd9);
        step(3);
        int_wb_req_i = 1'b1;
        step(2);
        int_wb_req_i = 1'b0;
        wait_idle("contend");
        check("contend_wb_once", 32'(n_wb), 1);
        check("contend_rd_hold", 32'(n_rdnz), 3);
        check("contend_wb_time", 32'(t_wb - t_start), 5);

        // Waitrequest in IDLE delays issue
        clear_stats();
        c0 = cyc;
        o_p_waitrequest = 1'b1; issue_valid_i = 1'b1; ops = ADD; rd_i = 5'd2;
        step(3);
        o_p_waitrequest = 1'b0;
        step(1);
        issue_valid_i = 1'b0; ops = 5'd0;
        wait_idle("waitreq_idle");
        check("waitreq_start", 32'(t_start - c0), 4);
        check("waitreq_starts", 32'(n_start), 1);

        // Waitrequest during EXEC leaves timing unchanged
        clear_stats();
        issue(MUL, 5'd0);
        o_p_waitrequest = 1'b1;
        step(6);
        o_p_waitrequest = 1'b0;
        wait_idle("waitreq_exec");
        check("waitreq_exec_lat", 32'(t_wb - t_start), 4);

        // Non-one-hot select
        clear_stats();
        c0 = cyc;
        issue(ADD | MUL, 5'd6);
        step(3);
        check("bad_err_cnt",  32'(n_err), 1);
        check("bad_err_time", 32'(t_err - c0), 1);
        check("bad_no_start", 32'(n_start), 0);

        // Reset mid-EXEC of fsqrt
        clear_stats();
        dec_fp_arith_i = 1'b1;
        issue(SQRT, 5'd11);
        step(5);
        rst = 1'b0;
        #1;
        check("rst_busy",  32'(busy_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_op",    32'(fpu_op_o), 0);
        check("rst_rd",    32'(fwb_rd_o), 0);
        dec_fp_arith_i = 1'b0;
        step(2);
        rst = 1'b1;
        step(20);
        check("rst_no_wb", 32'(n_wb), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
